// File: rtl/acumulador_somador.sv
// -----------------------------------------------------------------------------
// acumulador_somador
//
// Sequential accumulator wrapped around an external WIDTH-bit signed
// adder/subtractor. The block feeds the adder with the running sum and the
// current operand, takes the adder result back in the same cycle and
// registers it. A run starts on `start`, accepts N_OPS operands through a
// valid/ready handshake, then presents the total on a valid/ready result
// port together with a sticky overflow flag.
//
// Parameters
//   WIDTH   data width, two's complement (must match the external adder)
//   N_OPS   operands per accumulation run (>= 1)
//   SATURA  0 = wrap on overflow, 1 = clamp to the most positive/negative value
//
// Ports
//   clock        in   1      rising-edge clock
//   reset        in   1      synchronous, active-high; discards any partial run
//   start        in   1      begins a run (honoured only while idle)
//   op_valid     in   1      op_data/op_sinal carry an operand
//   op_ready     out  1      operand is accepted this cycle when op_valid=1
//   op_data      in   WIDTH  signed operand
//   op_sinal     in   1      0 = add operand, 1 = subtract operand
//   adder_a      out  WIDTH  to adder: current running sum
//   adder_b      out  WIDTH  to adder: op_data
//   adder_sinal  out  1      to adder: op_sinal
//   adder_soma   in   WIDTH  from adder: a+b or a-b
//   res_valid    out  1      res_data holds the final sum
//   res_ready    in   1      consumer takes the result
//   res_data     out  WIDTH  final (or last) sum
//   overflow     out  1      sticky: some step of this run overflowed
//   busy         out  1      run in progress or result pending
// -----------------------------------------------------------------------------
module acumulador_somador #(
    parameter int WIDTH  = 9,
    parameter int N_OPS  = 4,
    parameter bit SATURA = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_data,
    input  logic             op_sinal,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_sinal,
    input  logic [WIDTH-1:0] adder_soma,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             overflow,
    output logic             busy
);

    // Counter is sized to hold N_OPS itself, so it can never wrap.
    localparam int CW = $clog2(N_OPS + 1);
    localparam logic [CW-1:0]    LAST_IDX = CW'(N_OPS - 1);
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        ACUMULA = 2'b01,
        CONCLUI = 2'b10
    } estado_t;

    // Signed overflow of one add/sub step, judged from sign bits only.
    // Subtraction overflows when the operands differ in sign, addition when
    // they agree; in both cases the result sign departs from the sum sign.
    function automatic logic step_overflow(
        input logic sign_a,
        input logic sign_b,
        input logic sinal,
        input logic sign_soma
    );
        logic ovf;
        if (sinal) begin
            ovf = (sign_a != sign_b) && (sign_soma != sign_a);
        end else begin
            ovf = (sign_a == sign_b) && (sign_soma != sign_a);
        end
        return ovf;
    endfunction

    // Clamp value for an overflowed step: overflow always pushes past the
    // limit on the side of the current sum's sign.
    function automatic logic [WIDTH-1:0] clamp_value(input logic sign_a);
        logic [WIDTH-1:0] v;
        if (sign_a) begin
            v = MIN_NEG;
        end else begin
            v = MAX_POS;
        end
        return v;
    endfunction

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             op_ready_q, op_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic             accept_s;
    logic             last_s;
    logic             step_ovf_s;
    logic [WIDTH-1:0] next_sum_s;

    // Adder interface: purely combinational pass-through.
    assign adder_a     = sum_q;
    assign adder_b     = op_data;
    assign adder_sinal = op_sinal;

    // op_ready_q is only ever set while accumulating, so it qualifies accepts.
    assign accept_s   = op_valid & op_ready_q;
    assign last_s     = (count_q == LAST_IDX);
    assign step_ovf_s = step_overflow(sum_q[WIDTH-1], op_data[WIDTH-1],
                                      op_sinal, adder_soma[WIDTH-1]);

    // Value the running sum takes on an accepted step (wrap or clamp).
    always_comb begin
        next_sum_s = adder_soma;
        if (SATURA && step_ovf_s) begin
            next_sum_s = clamp_value(sum_q[WIDTH-1]);
        end else begin
            next_sum_s = adder_soma;
        end
    end

    // State and datapath registers; reset clears everything, including outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            sum_q       <= {WIDTH{1'b0}};
            count_q     <= {CW{1'b0}};
            ovf_q       <= 1'b0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic of the run controller.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    estado_d = ACUMULA;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            ACUMULA: begin
                if (accept_s && last_s) begin
                    estado_d = CONCLUI;
                end else begin
                    estado_d = ACUMULA;
                end
            end
            CONCLUI: begin
                if (res_ready) begin
                    estado_d = OCIOSO;
                end else begin
                    estado_d = CONCLUI;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Datapath next values: start clears the run only while idle; accepted
    // operands update sum and count. The result and overflow of the last run
    // stay visible while idle until the next start.
    always_comb begin
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    sum_d   = {WIDTH{1'b0}};
                    count_d = {CW{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    sum_d   = sum_q;
                    count_d = count_q;
                    ovf_d   = ovf_q;
                end
            end
            ACUMULA: begin
                if (accept_s) begin
                    sum_d   = next_sum_s;
                    count_d = count_q + CW'(1);
                    ovf_d   = ovf_q | step_ovf_s;
                end else begin
                    sum_d   = sum_q;
                    count_d = count_q;
                    ovf_d   = ovf_q;
                end
            end
            CONCLUI: begin
                sum_d   = sum_q;
                count_d = count_q;
                ovf_d   = ovf_q;
            end
            default: begin
                sum_d   = sum_q;
                count_d = count_q;
                ovf_d   = ovf_q;
            end
        endcase
    end

    // Output decode from the next state, so the handshake outputs are flops
    // that line up with the state they describe.
    always_comb begin
        op_ready_d  = 1'b0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (estado_d)
            OCIOSO: begin
                op_ready_d  = 1'b0;
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
            ACUMULA: begin
                op_ready_d  = 1'b1;
                res_valid_d = 1'b0;
                busy_d      = 1'b1;
            end
            CONCLUI: begin
                op_ready_d  = 1'b0;
                res_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: begin
                op_ready_d  = 1'b0;
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign res_data  = sum_q;
    assign overflow  = ovf_q;

endmodule
